// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: clog2, pointer-width derivation and
// elaboration-time sanity checks on depth and threshold parameters.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // One extra MSB beyond the array index distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int af_level, input int ae_level);
    return is_pow2(depth) && (depth >= 4) &&
           (af_level >= 0) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level < depth);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; master drives data in and
// accepts data out, slave is the FIFO itself.
interface sync_fifo_if
  import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int LW = ptr_width(DEPTH);

    logic [WIDTH-1:0] din;
    logic             din_dv;
    logic             din_rdy;
    logic [WIDTH-1:0] dout;
    logic             dout_dv;
    logic             dout_rdy;
    logic [LW-1:0]    level;
    logic             almost_full;
    logic             almost_empty;
    logic             err_clr;
    logic             ovf;

    modport master (
        output din, din_dv, dout_rdy, err_clr,
        input  din_rdy, dout, dout_dv, level, almost_full, almost_empty, ovf
    );

    modport slave (
        input  din, din_dv, dout_rdy, err_clr,
        output din_rdy, dout, dout_dv, level, almost_full, almost_empty, ovf
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers, and
    // leaving it out keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with valid/ready on both sides, fill level and
// almost-full/empty flags. Define SYNC_FIFO_ERR_EN for sticky overflow tracking.
module sync_fifo
  import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic         clk,
    input logic         rst_n,
    sync_fifo_if.slave  bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("sync_fifo: DEPTH must be a power of two >= 4, AF_LEVEL <= DEPTH, AE_LEVEL < DEPTH");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    level;
    logic [WIDTH-1:0] rd_data;
    logic             init_done;
    logic             full;
    logic             empty;
    logic             din_rdy;
    logic             wr_en;
    logic             rd_en;

    // Modular difference of the extended pointers is the occupancy, 0..DEPTH.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == PW'(DEPTH));
    assign empty   = (level == '0);
    assign din_rdy = init_done && !full;
    assign wr_en   = bus.din_dv && din_rdy;
    assign rd_en   = bus.dout_rdy && !empty;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.din),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign bus.din_rdy      = din_rdy;
    assign bus.dout_dv      = !empty;
    assign bus.dout         = empty ? '0 : rd_data;
    assign bus.level        = level;
    assign bus.almost_full  = (level >= PW'(AF_LEVEL));
    assign bus.almost_empty = (level <= PW'(AE_LEVEL));

`ifdef SYNC_FIFO_ERR_EN
    logic ovf;

    // Clear takes priority over a same-edge overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (bus.err_clr) begin
            ovf <= 1'b0;
        end else if (bus.din_dv && !din_rdy && init_done) begin
            ovf <= 1'b1;
        end
    end

    assign bus.ovf = ovf;
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign bus.ovf        = 1'b0;
`endif

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO: successor to the 16-deep, 1-bit clock-crossing FIFO for paths where producer and consumer share one clock but need a configurable width/depth buffer. Adds valid/ready handshakes on both sides, fill level, almost-full/almost-empty thresholds, and optional overflow tracking. Sits between a streaming producer and consumer inside one clock domain.

## Interface
- WIDTH, 8, data width in bits, ≥1
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when LEVEL ≥ AF_LEVEL
- AE_LEVEL, 2, ALMOST_EMPTY asserts when LEVEL ≤ AE_LEVEL
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- DIN  in  WIDTH  write data
- DIN_DV  in  1  write data valid
- DIN_RDY  out  1  FIFO can accept; write occurs on DIN_DV && DIN_RDY
- DOUT  out  WIDTH  head-of-FIFO data, show-ahead
- DOUT_DV  out  1  DOUT valid (FIFO not empty)
- DOUT_RDY  in  1  consumer accepts; read occurs on DOUT_DV && DOUT_RDY
- LEVEL  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- ALMOST_FULL  out  1  LEVEL ≥ AF_LEVEL
- ALMOST_EMPTY  out  1  LEVEL ≤ AE_LEVEL
- ERR_CLR  in  1  clears OVF (see Configuration)
- OVF  out  1  sticky overflow flag

## Operation
- Storage: DEPTH×WIDTH register array, not reset. Write and read pointers are clog2(DEPTH)+1 bits; lower bits index the array, MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH naturally.
- LEVEL = wr_ptr − rd_ptr (modular, pointer width). Empty: LEVEL==0. Full: LEVEL==DEPTH.
- Write: on DIN_DV && DIN_RDY, mem[wr_ptr] ← DIN, wr_ptr+1.
- Read: on DOUT_DV && DOUT_RDY, rd_ptr+1. DOUT = mem[rd_ptr] when DOUT_DV=1, else all-zero.
- DIN_RDY = init_done && !full; init_done is a register cleared by reset, set at first rising edge after RST_N release.
- DOUT_DV = !empty.
- Simultaneous write+read: both occur, LEVEL unchanged. When full, DIN_RDY=0 even if a read happens that cycle (no pass-through). When empty, read impossible; write proceeds.
- DIN_DV while DIN_RDY=0: data dropped, pointers unchanged.
- DOUT_RDY while DOUT_DV=0: ignored.
- Reset mid-operation: contents lost, pointers zeroed immediately, all outputs go to reset values asynchronously.

## Timing
- Reset values: DIN_RDY=0, DOUT_DV=0, DOUT=0, LEVEL=0, ALMOST_FULL=(AF_LEVEL==0), ALMOST_EMPTY=1, OVF=0.
- DIN_RDY rises at first CLK edge after RST_N deasserts.
- Write-to-read latency: word written at edge k is on DOUT with DOUT_DV=1 after edge k (1 cycle).
- LEVEL, ALMOST_*, DIN_RDY, DOUT_DV update after the edge on which the transfer occurs; all derived from registered pointers (no combinational path from DIN_DV/DOUT_RDY to any output).
- Full throughput: one write and one read per cycle sustained.

## Configuration
- SYNC_FIFO_ERR_EN defined: OVF set on any edge with DIN_DV=1 && DIN_RDY=0 && init_done=1; stays set until an edge with ERR_CLR=1 (clear wins over simultaneous set). Cleared by reset.
- Not defined: OVF tied to 0, ERR_CLR ignored; ports remain present.

## Structure
- Shared package fifo_pkg: clog2 function, pointer-width derivation, threshold sanity checks (AF_LEVEL ≤ DEPTH, AE_LEVEL < DEPTH, DEPTH power of two) reported at elaboration.
- One sub-module: fifo_mem, WIDTH×DEPTH register array, synchronous write port, asynchronous read port.

## Test plan
- Reset release, WIDTH=8 DEPTH=16: DIN_RDY=0 during reset, 1 one edge after release; LEVEL=0, DOUT_DV=0, ALMOST_EMPTY=1.
- Write 16 words 0x00..0x0F back-to-back, DOUT_RDY=0 -> LEVEL=16, DIN_RDY=0, ALMOST_FULL=1 from LEVEL 14; then drain -> DOUT reads 0x00..0x0F in order.
- Full FIFO, 17th write with DIN_DV=1 -> dropped, LEVEL stays 16; with SYNC_FIFO_ERR_EN OVF=1 until ERR_CLR pulse, without it OVF=0.
- Continuous write+read at LEVEL=5 for 40 cycles (pointer wrap ×2) -> LEVEL constant 5, output sequence matches input order.
- Write 0xA5 to empty FIFO at edge k -> DOUT=0xA5, DOUT_DV=1 after edge k; DOUT_RDY=1 -> DOUT_DV=0, DOUT=0 after edge k+1.
- Assert RST_N low with LEVEL=9 -> LEVEL=0, DOUT_DV=0, DIN_RDY=0 immediately, without clock edge.
